fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of imem.
- Owns the program counter and drives imem's pc port; imem read is combinational, so the word returns in the same cycle.
- Captures pc/instr into an IF/ID register with a valid/ready handshake toward decode.
- Accepts redirects (branch/jump) from execute; a redirect flushes the IF/ID slot.

---
 rtl/riscv_pkg.sv | 8 +
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit_if_id_reg.sv | 41 ++++
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: widths, the canonical NOP and the fetch FSM states.
package riscv_pkg;
  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {RUN, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem address/data, execute redirect and the IF/ID handshake.
// misalign_err is present only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] imem_pc;
  logic [31:0]     imem_instr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misalign_err;
`endif

  // fetch side
  modport master (
    output imem_pc, id_valid, id_pc, id_instr, id_pc_plus4,
`ifdef FETCH_MISALIGN_TRAP_EN
    output misalign_err,
`endif
    input  imem_instr, redirect_valid, redirect_pc, id_ready
  );

  // imem / execute / decode side
  modport slave (
    input  imem_pc, id_valid, id_pc, id_instr, id_pc_plus4,
`ifdef FETCH_MISALIGN_TRAP_EN
    input  misalign_err,
`endif
    output imem_instr, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Priority: reset, flush, kill, load, hold.
// flush drops the slot and parks a NOP; kill only clears valid (trap path).
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic            kill,
  input  logic [XLEN-1:0] ld_pc,
  input  logic [31:0]     ld_instr,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc_plus4
);

  // slot update
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_instr    <= NOP_INSTR;
      id_pc_plus4 <= XLEN'(4);
    end else if (flush) begin
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
    end else if (kill) begin
      id_valid    <= 1'b0;
    end else if (load) begin
      id_valid    <= 1'b1;
      id_pc       <= ld_pc;
      id_instr    <= ld_instr;
      id_pc_plus4 <= ld_pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: pc register, next-pc selection, RUN/HALT FSM and IF/ID slot.
// Optional: FETCH_MISALIGN_TRAP_EN halts on a misaligned redirect target.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic clk,
  input  logic reset,
  fetch_if.master bus
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            run, slot_free, load, flush, kill, misaligned;

  assign bus.imem_pc = pc;

  // slot control is derived from registered state plus this cycle's inputs
  always_comb begin
    run        = (state == RUN);
    slot_free  = !bus.id_valid || bus.id_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned = (bus.redirect_pc[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    flush      = run && bus.redirect_valid && !misaligned;
    kill       = run && bus.redirect_valid && misaligned;
    load       = run && !bus.redirect_valid && slot_free;
  end

  // pc register and FSM; HALT freezes pc until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
      bus.misalign_err <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (bus.redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
              state            <= HALT;
              bus.misalign_err <= 1'b1;
              pc               <= bus.redirect_pc;  // unmasked so the bad target is visible
            end else begin
              pc <= bus.redirect_pc;
            end
`else
            pc <= bus.redirect_pc & ~XLEN'(3);
`endif
          end else if (slot_free) begin
            pc <= pc + XLEN'(4);
          end
        end
        HALT: ;
        default: state <= RUN;
      endcase
    end
  end

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .flush       (flush),
    .kill        (kill),
    .ld_pc       (pc),
    .ld_instr    (bus.imem_instr),
    .id_valid    (bus.id_valid),
    .id_pc       (bus.id_pc),
    .id_instr    (bus.id_instr),
    .id_pc_plus4 (bus.id_pc_plus4)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a behavioural model of the fetch rules. Second instance covers pc wrap.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic w_reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  fetch_if #(.XLEN(32)) bus ();
  fetch_if #(.XLEN(32)) wbus ();

  fetch_unit #(.RESET_PC(32'h0), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .XLEN(32)) dut_wrap (
    .clk(clk), .reset(w_reset), .bus(wbus)
  );

  // imem contents: arbitrary hash, with the known word at 8
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h8) return 32'h0000_07b7;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign bus.imem_instr  = mem_f(bus.imem_pc);
  assign wbus.imem_instr = mem_f(wbus.imem_pc);

  // behavioural model of the fetch stage
  logic [31:0] m_pc, m_idpc, m_instr, m_p4;
  logic        m_v, m_halt, m_err;

  task automatic model_step();
    if (reset) begin
      m_pc = 32'h0; m_v = 0; m_idpc = 0; m_instr = NOP; m_p4 = 4;
      m_halt = 0; m_err = 0;
    end else if (m_halt) begin
      // frozen
    end else if (bus.redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (bus.redirect_pc[1:0] != 0) begin
        m_halt = 1; m_err = 1; m_pc = bus.redirect_pc; m_v = 0;
      end else begin
        m_pc = bus.redirect_pc; m_v = 0; m_instr = NOP;
      end
`else
      m_pc = {bus.redirect_pc[31:2], 2'b00}; m_v = 0; m_instr = NOP;
`endif
    end else if (!m_v || bus.id_ready) begin
      m_idpc = m_pc; m_instr = mem_f(m_pc); m_p4 = m_pc + 4; m_v = 1;
      m_pc = m_pc + 4;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; bus.id_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    wbus.id_ready = 0; wbus.redirect_valid = 0; wbus.redirect_pc = 0;
    tick(); tick();
    n_total++; if (bus.imem_pc !== 32'h0) $display("FAIL rst_pc act=%h exp=0", bus.imem_pc); else n_pass++;
    n_total++; if (bus.id_valid !== 1'b0) $display("FAIL rst_valid act=%b exp=0", bus.id_valid); else n_pass++;
    n_total++; if (bus.id_pc !== 32'h0) $display("FAIL rst_idpc act=%h exp=0", bus.id_pc); else n_pass++;
    n_total++; if (bus.id_instr !== NOP) $display("FAIL rst_instr act=%h exp=%h", bus.id_instr, NOP); else n_pass++;
    n_total++; if (bus.id_pc_plus4 !== 32'h4) $display("FAIL rst_p4 act=%h exp=4", bus.id_pc_plus4); else n_pass++;
`ifdef FETCH_MISALIGN_TRAP_EN
    n_total++; if (bus.misalign_err !== 1'b0) $display("FAIL rst_err act=%b exp=0", bus.misalign_err); else n_pass++;
`endif
  endtask

  task automatic test_fetch();
    reset = 0; bus.id_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (bus.imem_pc !== 32'(4*i+4)) $display("FAIL seq_pc%0d act=%h exp=%h", i, bus.imem_pc, 32'(4*i+4)); else n_pass++;
      n_total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4*i)) $display("FAIL seq_id%0d act=%b/%h exp=1/%h", i, bus.id_valid, bus.id_pc, 32'(4*i)); else n_pass++;
      n_total++; if (bus.id_instr !== mem_f(32'(4*i))) $display("FAIL seq_instr%0d act=%h exp=%h", i, bus.id_instr, mem_f(32'(4*i))); else n_pass++;
    end
    n_total++; if (bus.id_instr !== 32'h0000_07b7) $display("FAIL seq_word8 act=%h exp=000007b7", bus.id_instr); else n_pass++;
  endtask

  task automatic test_stall();
    bus.id_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (bus.id_pc !== 32'h8 || bus.id_instr !== 32'h7b7 || bus.imem_pc !== 32'hC)
        $display("FAIL stall%0d act=%h/%h/%h exp=8/7b7/c", i, bus.id_pc, bus.id_instr, bus.imem_pc); else n_pass++;
    end
    bus.id_ready = 1;
    tick();
    n_total++; if (bus.id_pc !== 32'hC || bus.id_instr !== mem_f(32'hC) || bus.imem_pc !== 32'h10)
      $display("FAIL stall_release act=%h/%h/%h exp=c/%h/10", bus.id_pc, bus.id_instr, bus.imem_pc, mem_f(32'hC)); else n_pass++;
  endtask

  task automatic test_redirect();
    bus.id_ready = 0; bus.redirect_valid = 1; bus.redirect_pc = 32'h20;
    tick();
    bus.redirect_valid = 0; bus.id_ready = 1;
    n_total++; if (bus.id_valid !== 0 || bus.id_instr !== NOP || bus.imem_pc !== 32'h20)
      $display("FAIL redir_flush act=%b/%h/%h exp=0/%h/20", bus.id_valid, bus.id_instr, bus.imem_pc, NOP); else n_pass++;
    tick();
    n_total++; if (bus.id_valid !== 1 || bus.id_pc !== 32'h20 || bus.id_pc_plus4 !== 32'h24)
      $display("FAIL redir_target act=%b/%h/%h exp=1/20/24", bus.id_valid, bus.id_pc, bus.id_pc_plus4); else n_pass++;
  endtask

  task automatic test_misalign();
    bus.id_ready = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h22;
    tick();
    bus.redirect_valid = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    n_total++; if (bus.misalign_err !== 1 || bus.imem_pc !== 32'h22 || bus.id_valid !== 0)
      $display("FAIL mis_trap act=%b/%h/%b exp=1/22/0", bus.misalign_err, bus.imem_pc, bus.id_valid); else n_pass++;
    bus.redirect_valid = 1; bus.redirect_pc = 32'h40;
    tick();
    bus.redirect_valid = 0;
    tick(); tick();
    n_total++; if (bus.misalign_err !== 1 || bus.imem_pc !== 32'h22 || bus.id_valid !== 0)
      $display("FAIL mis_halt act=%b/%h/%b exp=1/22/0", bus.misalign_err, bus.imem_pc, bus.id_valid); else n_pass++;
    reset = 1; tick(); reset = 0;
    n_total++; if (bus.misalign_err !== 0 || bus.imem_pc !== 32'h0)
      $display("FAIL mis_reset act=%b/%h exp=0/0", bus.misalign_err, bus.imem_pc); else n_pass++;
`else
    n_total++; if (bus.imem_pc !== 32'h20 || bus.id_valid !== 0)
      $display("FAIL mis_mask act=%h/%b exp=20/0", bus.imem_pc, bus.id_valid); else n_pass++;
    tick();
    n_total++; if (bus.id_pc !== 32'h20 || bus.id_valid !== 1 || bus.imem_pc !== 32'h24)
      $display("FAIL mis_continue act=%h/%b/%h exp=20/1/24", bus.id_pc, bus.id_valid, bus.imem_pc); else n_pass++;
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset              = ($urandom_range(0, 59) == 0);
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 7) == 0);
      bus.redirect_pc    = 32'($urandom_range(0, 511)) & ~32'h1;
      tick();
      n_total++;
      if (bus.imem_pc !== m_pc || bus.id_valid !== m_v || bus.id_pc !== m_idpc ||
          bus.id_instr !== m_instr || bus.id_pc_plus4 !== m_p4)
        $display("FAIL rand%0d act=%h/%b/%h/%h/%h exp=%h/%b/%h/%h/%h", i,
                 bus.imem_pc, bus.id_valid, bus.id_pc, bus.id_instr, bus.id_pc_plus4,
                 m_pc, m_v, m_idpc, m_instr, m_p4);
      else n_pass++;
`ifdef FETCH_MISALIGN_TRAP_EN
      n_total++; if (bus.misalign_err !== m_err) $display("FAIL rand_err%0d act=%b exp=%b", i, bus.misalign_err, m_err); else n_pass++;
`endif
    end
    reset = 0; bus.redirect_valid = 0;
  endtask

  task automatic test_reset_mid();
    bus.id_ready = 1; bus.redirect_valid = 0;
    tick(); tick();
    n_total++; if (bus.id_valid !== 1) $display("FAIL mid_pre act=%b exp=1", bus.id_valid); else n_pass++;
    reset = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h80;
    tick();
    reset = 0; bus.redirect_valid = 0;
    n_total++; if (bus.imem_pc !== 0 || bus.id_valid !== 0 || bus.id_pc !== 0 || bus.id_instr !== NOP || bus.id_pc_plus4 !== 4)
      $display("FAIL mid_reset act=%h/%b/%h/%h/%h exp=0/0/0/%h/4", bus.imem_pc, bus.id_valid, bus.id_pc, bus.id_instr, bus.id_pc_plus4, NOP); else n_pass++;
    tick();
    n_total++; if (bus.id_pc !== 0 || bus.id_valid !== 1 || bus.imem_pc !== 32'h4)
      $display("FAIL mid_resume act=%h/%b/%h exp=0/1/4", bus.id_pc, bus.id_valid, bus.imem_pc); else n_pass++;
  endtask

  task automatic test_wrap();
    w_reset = 1; wbus.id_ready = 1; wbus.redirect_valid = 0;
    tick();
    n_total++; if (wbus.imem_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_rst act=%h exp=fffffffc", wbus.imem_pc); else n_pass++;
    w_reset = 0;
    tick();
    n_total++; if (wbus.imem_pc !== 32'h0 || wbus.id_pc !== 32'hFFFF_FFFC || wbus.id_pc_plus4 !== 32'h0 || wbus.id_valid !== 1)
      $display("FAIL wrap act=%h/%h/%h/%b exp=0/fffffffc/0/1", wbus.imem_pc, wbus.id_pc, wbus.id_pc_plus4, wbus.id_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    n_total++; if (bus.imem_pc !== 32'h0) $display("FAIL seq_start act=%h exp=0", bus.imem_pc); else n_pass++;
    test_fetch();
    test_stall();
    test_redirect();
    test_misalign();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
